// File: rtl/sound_reg_bank.sv
// Configurable control/status register bank for the sound core.
// Supports RW, RO, W1C and SHADOW registers, with a single-outstanding request/response port.
module sound_reg_bank #(
    parameter int                           DATA_W       = 16,
    parameter int                           NUM_REGS     = 16,
    parameter int                           ADDR_W       = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0]          RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]          W1C_MASK     = '0,
    parameter logic [NUM_REGS-1:0]          SHADOW_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALUES = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W-1:0]            req_wmask,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    input  logic                         commit,
    output logic                         commit_pending,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         irq
);

    // Mode precedence resolved once: RO > W1C > SHADOW > RW.
    localparam logic [NUM_REGS-1:0] IS_RO  = RO_MASK;
    localparam logic [NUM_REGS-1:0] IS_W1C = W1C_MASK & ~RO_MASK;
    localparam logic [NUM_REGS-1:0] IS_SH  = SHADOW_MASK & ~W1C_MASK & ~RO_MASK;

    logic                accept;
    logic                wr_acc;
    logic                addr_ok;
    logic                ro_hit;
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   rd_val [NUM_REGS];
    logic [NUM_REGS-1:0] sh_wr;
    logic [NUM_REGS-1:0] w1c_any;
    logic                unused_inputs;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [DATA_W-1:0] wmask);
        return (old_v & ~wmask) | (wdata & wmask);
    endfunction

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_write;
    assign addr_ok   = int'(req_addr) < NUM_REGS;

    // Status/set lanes belonging to registers of other modes are don't-care.
    assign unused_inputs = ^{hw_status, hw_set};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [DATA_W-1:0] RST_V = RESET_VALUES[i*DATA_W +: DATA_W];

        if (IS_RO[i]) begin : g_ro
            assign rd_val[i]                   = hw_status[i*DATA_W +: DATA_W];
            assign regs_out[i*DATA_W +: DATA_W] = hw_status[i*DATA_W +: DATA_W];
            assign sh_wr[i]                    = 1'b0;
            assign w1c_any[i]                  = 1'b0;
        end else if (IS_W1C[i]) begin : g_w1c
            logic              hit;
            logic [DATA_W-1:0] clr;
            logic [DATA_W-1:0] flag_q;

            assign hit = wr_acc && (req_addr == ADDR_W'(i));
            assign clr = hit ? (req_wdata & req_wmask) : '0;

            // Set is OR-ed in after the clear so a same-cycle set wins.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) flag_q <= '0;
                else        flag_q <= (flag_q & ~clr) | hw_set[i*DATA_W +: DATA_W];
            end

            assign rd_val[i]                   = flag_q;
            assign regs_out[i*DATA_W +: DATA_W] = flag_q;
            assign sh_wr[i]                    = 1'b0;
            assign w1c_any[i]                  = |flag_q;
        end else if (IS_SH[i]) begin : g_sh
            logic              hit;
            logic [DATA_W-1:0] shadow_q;
            logic [DATA_W-1:0] active_q;
            logic [DATA_W-1:0] shadow_nxt;

            assign hit        = wr_acc && (req_addr == ADDR_W'(i));
            assign shadow_nxt = hit ? merge(shadow_q, req_wdata, req_wmask) : shadow_q;

            // Commit copies the post-write shadow, so a coincident write lands in active too.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q <= RST_V;
                    active_q <= RST_V;
                end else begin
                    shadow_q <= shadow_nxt;
                    if (commit) active_q <= shadow_nxt;
                end
            end

            assign rd_val[i]                   = shadow_q;
            assign regs_out[i*DATA_W +: DATA_W] = active_q;
            assign sh_wr[i]                    = hit;
            assign w1c_any[i]                  = 1'b0;
        end else begin : g_rw
            logic              hit;
            logic [DATA_W-1:0] active_q;

            assign hit = wr_acc && (req_addr == ADDR_W'(i));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   active_q <= RST_V;
                else if (hit) active_q <= merge(active_q, req_wdata, req_wmask);
            end

            assign rd_val[i]                   = active_q;
            assign regs_out[i*DATA_W +: DATA_W] = active_q;
            assign sh_wr[i]                    = 1'b0;
            assign w1c_any[i]                  = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                rd_mux = rd_val[i];
                ro_hit = IS_RO[i];
            end
        end
    end

    // Response stage: captured at acceptance, held until rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !addr_ok || (req_write && ro_hit);
            rsp_rdata <= (req_write || !addr_ok) ? '0 : rd_mux;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            irq            <= 1'b0;
        end else begin
            if (commit)      commit_pending <= 1'b0;
            else if (|sh_wr) commit_pending <= 1'b1;
            irq <= |w1c_any;
        end
    end

endmodule

// File: tb/tb_sound_reg_bank.sv
// Directed bench for sound_reg_bank: reg1 RW, reg2 RW, reg3 SHADOW, reg4 W1C, reg5 RO.
// ADDR_W is widened to 5 so out-of-range addresses can be driven.
module tb_sound_reg_bank;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 5;
    localparam logic [NR*DW-1:0] RV = ((NR*DW)'(16'h1234) << 32) |
                                      ((NR*DW)'(16'hFFFF) << 16) |
                                      ((NR*DW)'(16'h0003) << 48);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic [DW-1:0]     req_wmask = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              commit = 1'b0;
    logic              commit_pending;
    logic [NR*DW-1:0]  hw_status = '0;
    logic [NR*DW-1:0]  hw_set = '0;
    logic [NR*DW-1:0]  regs_out;
    logic              irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic          v;
    logic [DW-1:0] r;
    logic          e;

    sound_reg_bank #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
        .RO_MASK(16'h0020), .W1C_MASK(16'h0010), .SHADOW_MASK(16'h0008),
        .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .commit(commit), .commit_pending(commit_pending),
        .hw_status(hw_status), .hw_set(hw_set), .regs_out(regs_out), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] rout(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    // Called at a falling edge; the request is accepted at the next rising edge.
    task automatic xact(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, output logic vo, output logic [DW-1:0] ro,
                        output logic eo);
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_wdata = wd; req_wmask = wm; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vo = rsp_valid; ro = rsp_rdata; eo = rsp_err;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        vec_cnt++; if (commit_pending !== 1'b0) begin err_cnt++; $display("FAIL rst_pending got %b exp 0", commit_pending); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL rst_irq got %b exp 0", irq); end
        vec_cnt++; if (rout(2) !== 16'h1234) begin err_cnt++; $display("FAIL rst_reg2 got %h exp 1234", rout(2)); end
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 5'd2, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (v !== 1'b1) begin err_cnt++; $display("FAIL rd2_valid got %b exp 1", v); end
        vec_cnt++; if (r !== 16'h1234) begin err_cnt++; $display("FAIL rd2_data got %h exp 1234", r); end
        vec_cnt++; if (e !== 1'b0) begin err_cnt++; $display("FAIL rd2_err got %b exp 0", e); end
        xact(1'b0, 5'd4, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'h0000) begin err_cnt++; $display("FAIL rd4_w1c_rst got %h exp 0000", r); end
        vec_cnt++; if (rout(3) !== 16'h0003) begin err_cnt++; $display("FAIL rst_reg3 got %h exp 0003", rout(3)); end
    endtask

    task automatic test_rw;
        xact(1'b1, 5'd1, 16'h0000, 16'h00F0, v, r, e);
        vec_cnt++; if (e !== 1'b0 || r !== 16'h0) begin err_cnt++; $display("FAIL rw_wr_rsp got err=%b rd=%h exp err=0 rd=0000", e, r); end
        xact(1'b0, 5'd1, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'hFF0F) begin err_cnt++; $display("FAIL rw_merge got %h exp ff0f", r); end
        vec_cnt++; if (rout(1) !== 16'hFF0F) begin err_cnt++; $display("FAIL rw_out got %h exp ff0f", rout(1)); end
        xact(1'b1, 5'd16, 16'h0000, 16'hFFFF, v, r, e);
        vec_cnt++; if (e !== 1'b1 || r !== 16'h0) begin err_cnt++; $display("FAIL bad_wr got err=%b rd=%h exp err=1 rd=0000", e, r); end
        xact(1'b0, 5'd1, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'hFF0F) begin err_cnt++; $display("FAIL bad_wr_side got %h exp ff0f", r); end
        vec_cnt++; if (rout(0) !== 16'h0000) begin err_cnt++; $display("FAIL bad_wr_reg0 got %h exp 0000", rout(0)); end
        xact(1'b0, 5'd16, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (e !== 1'b1 || r !== 16'h0) begin err_cnt++; $display("FAIL bad_rd got err=%b rd=%h exp err=1 rd=0000", e, r); end
    endtask

    task automatic test_shadow;
        xact(1'b1, 5'd3, 16'hABCD, 16'hFFFF, v, r, e);
        vec_cnt++; if (rout(3) !== 16'h0003) begin err_cnt++; $display("FAIL sh_precommit got %h exp 0003", rout(3)); end
        vec_cnt++; if (commit_pending !== 1'b1) begin err_cnt++; $display("FAIL sh_pending got %b exp 1", commit_pending); end
        xact(1'b0, 5'd3, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'hABCD) begin err_cnt++; $display("FAIL sh_read got %h exp abcd", r); end
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        vec_cnt++; if (rout(3) !== 16'hABCD) begin err_cnt++; $display("FAIL sh_commit got %h exp abcd", rout(3)); end
        vec_cnt++; if (commit_pending !== 1'b0) begin err_cnt++; $display("FAIL sh_pend_clr got %b exp 0", commit_pending); end
        commit = 1'b1;
        xact(1'b1, 5'd3, 16'h5A5A, 16'hFFFF, v, r, e);
        commit = 1'b0;
        vec_cnt++; if (rout(3) !== 16'h5A5A) begin err_cnt++; $display("FAIL sh_coinc got %h exp 5a5a", rout(3)); end
        vec_cnt++; if (commit_pending !== 1'b0) begin err_cnt++; $display("FAIL sh_coinc_pend got %b exp 0", commit_pending); end
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        vec_cnt++; if (rout(3) !== 16'h5A5A) begin err_cnt++; $display("FAIL sh_idle_commit got %h exp 5a5a", rout(3)); end
    endtask

    task automatic test_w1c;
        hw_set[4*DW +: DW] = 16'h0005;
        @(negedge clk);
        hw_set = '0;
        vec_cnt++; if (rout(4) !== 16'h0005) begin err_cnt++; $display("FAIL w1c_set got %h exp 0005", rout(4)); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_early got %b exp 0", irq); end
        @(negedge clk);
        vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_set got %b exp 1", irq); end
        xact(1'b1, 5'd4, 16'h0001, 16'hFFFF, v, r, e);
        vec_cnt++; if (rout(4) !== 16'h0004) begin err_cnt++; $display("FAIL w1c_clr got %h exp 0004", rout(4)); end
        xact(1'b0, 5'd4, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'h0004) begin err_cnt++; $display("FAIL w1c_read got %h exp 0004", r); end
        hw_set[4*DW +: DW] = 16'h0004;
        xact(1'b1, 5'd4, 16'h0004, 16'hFFFF, v, r, e);
        hw_set = '0;
        vec_cnt++; if (rout(4) !== 16'h0004) begin err_cnt++; $display("FAIL w1c_set_wins got %h exp 0004", rout(4)); end
        hw_set[1*DW +: DW] = 16'hFFFF;
        @(negedge clk);
        hw_set = '0;
        vec_cnt++; if (rout(1) !== 16'hFF0F) begin err_cnt++; $display("FAIL set_non_w1c got %h exp ff0f", rout(1)); end
        xact(1'b1, 5'd4, 16'h0004, 16'hFFFF, v, r, e);
        vec_cnt++; if (rout(4) !== 16'h0000) begin err_cnt++; $display("FAIL w1c_clr_all got %h exp 0000", rout(4)); end
        @(negedge clk);
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_clr got %b exp 0", irq); end
    endtask

    task automatic test_ro;
        hw_status[5*DW +: DW] = 16'h0BEE;
        #1;
        vec_cnt++; if (rout(5) !== 16'h0BEE) begin err_cnt++; $display("FAIL ro_out got %h exp 0bee", rout(5)); end
        @(negedge clk);
        xact(1'b0, 5'd5, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'h0BEE || e !== 1'b0) begin err_cnt++; $display("FAIL ro_read got rd=%h err=%b exp rd=0bee err=0", r, e); end
        xact(1'b1, 5'd5, 16'hFFFF, 16'hFFFF, v, r, e);
        vec_cnt++; if (e !== 1'b1 || r !== 16'h0) begin err_cnt++; $display("FAIL ro_write got err=%b rd=%h exp err=1 rd=0000", e, r); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd2;
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin err_cnt++; $display("FAIL bb_first got v=%b rd=%h exp v=1 rd=1234", rsp_valid, rsp_rdata); end
        req_addr = 5'd1;
        for (int k = 0; k < 3; k++) begin
            vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL bb_stall_ready cyc %0d got %b exp 0", k, req_ready); end
            vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin err_cnt++; $display("FAIL bb_hold cyc %0d got v=%b rd=%h exp v=1 rd=1234", k, rsp_valid, rsp_rdata); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL bb_release got %b exp 1", req_ready); end
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hFF0F) begin err_cnt++; $display("FAIL bb_second got v=%b rd=%h exp v=1 rd=ff0f", rsp_valid, rsp_rdata); end
        req_addr = 5'd2;
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin err_cnt++; $display("FAIL bb_third got v=%b rd=%h exp v=1 rd=1234", rsp_valid, rsp_rdata); end
        req_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL bb_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd2;
        @(negedge clk);
        req_valid = 1'b0;
        vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_pre got %b exp 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_drop got %b exp 0", rsp_valid); end
        vec_cnt++; if (rout(1) !== 16'hFFFF) begin err_cnt++; $display("FAIL mid_reg1 got %h exp ffff", rout(1)); end
        vec_cnt++; if (rout(3) !== 16'h0003) begin err_cnt++; $display("FAIL mid_reg3 got %h exp 0003", rout(3)); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        xact(1'b0, 5'd3, 16'h0, 16'h0, v, r, e);
        vec_cnt++; if (r !== 16'h0003) begin err_cnt++; $display("FAIL mid_shadow got %h exp 0003", r); end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_shadow();
        test_w1c();
        test_ro();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sound_reg_bank.md
Name: sound_reg_bank

Overview:
- Parametrised control/status register bank for the sound core, built as a successor to the fixed 16x16 register set.
- Register width, register count and a per-register access mode are all configurable. Modes are RW, RO (hardware status), W1C (sticky event flags) and SHADOW (double-buffered RW).
- Sits between the host bus bridge and the synth/mixer datapath.
- SHADOW registers apply to the datapath only on a sample-frame commit strobe, so multi-register updates are glitch-free.

Parameters:
- DATA_W, 16: register width in bits.
- NUM_REGS, 16: number of registers.
- ADDR_W, $clog2(NUM_REGS): request address width.
- RO_MASK, '0 (NUM_REGS bits): bit i=1 makes register i read-only hardware status.
- W1C_MASK, '0 (NUM_REGS bits): bit i=1 makes register i sticky write-1-to-clear.
- SHADOW_MASK, '0 (NUM_REGS bits): bit i=1 makes register i double-buffered RW.
- RESET_VALUES, '0 (NUM_REGS*DATA_W bits): reset value of RW/SHADOW register i is slice [i*DATA_W +: DATA_W].

Ports:
- clk, in, 1: core clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request valid.
- req_ready, out, 1: request ready.
- req_write, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: register index.
- req_wdata, in, DATA_W: write data.
- req_wmask, in, DATA_W: per-bit write enable.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: response accepted.
- rsp_rdata, out, DATA_W: read data (0 for writes and errors).
- rsp_err, out, 1: bad address or write to RO.
- commit, in, 1: frame strobe; copies all shadow values to active.
- commit_pending, out, 1: a shadow write is awaiting commit.
- hw_status, in, NUM_REGS*DATA_W: live values for RO registers.
- hw_set, in, NUM_REGS*DATA_W: set pulses for W1C bits.
- regs_out, out, NUM_REGS*DATA_W: active register values to the datapath.
- irq, out, 1: OR of all W1C register bits.

Behaviour:
- Mode precedence per register: RO > W1C > SHADOW > plain RW.
- Reset (async assert, sync-safe deassert):
  - active and shadow = RESET_VALUES; W1C registers = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, commit_pending=0, irq=0.
  - Reset mid-transaction drops the pending response.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready, giving at most one outstanding response.
  - A request is accepted on req_valid && req_ready.
  - rsp_valid rises the cycle after acceptance and holds with stable rsp_rdata/rsp_err until rsp_ready.
  - Back-to-back throughput is 1/cycle while rsp_ready=1.
- Address >= NUM_REGS: rsp_err=1, rdata=0, no state change.
- Write merge: new = (old & ~req_wmask) | (req_wdata & req_wmask). State updates at the acceptance edge.
- RW: merge into active.
- SHADOW:
  - Merge into shadow and set commit_pending.
  - On commit, active <= shadow for every SHADOW register and commit_pending clears.
  - Commit and shadow write in the same cycle: the merged value goes to both shadow and active; commit_pending ends 0.
- RO: a write gives rsp_err=1 with no effect. A read returns hw_status slice sampled at acceptance.
- W1C:
  - Each cycle reg <= (reg & ~clr) | hw_set_slice, where clr = req_wdata & req_wmask on an accepted write, else 0.
  - Set wins over clear on the same bit in the same cycle.
  - hw_set on non-W1C registers is ignored.
- Read data:
  - RW returns active; SHADOW returns shadow.
  - W1C returns the value before any same-cycle set/clear.
  - Read data is captured at acceptance.
- regs_out: RW/SHADOW carry active, W1C carry the register value, RO carry hw_status passthrough.
- irq is registered: 1 cycle after any W1C bit becomes set.
- commit with no pending shadow writes: no change.

Test Plan:
- Reset with RESET_VALUES reg2=0x1234, then read addr 2 -> rsp_valid 1 cycle after accept, rdata=0x1234, err=0; W1C regs read 0.
- RW reg1=0xFFFF, write wdata=0x0000 wmask=0x00F0 -> reads back 0xFF0F; write addr 16 (NUM_REGS=16) -> err=1, no register changes.
- SHADOW reg3: write 0xABCD -> regs_out slice 3 unchanged and commit_pending=1; pulse commit -> slice 3=0xABCD, pending=0. Write coincident with commit -> active updated same edge.
- W1C reg4: hw_set=0x0005 -> reg=0x0005, irq=1 next cycle; write 0x0001 -> reg=0x0004. Clear bit2 while hw_set bit2 is high -> bit2 stays 1.
- RO reg5: hw_status=0x0BEE, read -> rdata=0x0BEE; write -> err=1.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp stable, second request accepted only on the cycle rsp_ready=1. Assert rst_n low mid-response -> rsp_valid=0 immediately.
